// File: rtl/mem_defs.sv
// mem_defs: shared definitions for the memory pipeline stage.
//   - memop_t      : memory operation codes carried from EX into M
//   - mem_state_t  : bus-access FSM state encoding
//   - SIZE_*       : data_size encodings on the data bus
//   - m_reg_t      : contents of the M pipeline register
//   - is_load / is_store helpers
package mem_defs;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } memop_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } mem_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] aluout;
        logic [31:0] writedata;
        logic [4:0]  writereg;
        logic        regwrite;
        memop_t      memop;
        logic        hilo_write;
        logic [63:0] hilo;
        logic        adel;
        logic        ades;
        logic [31:0] badvaddr;
    } m_reg_t;

    function automatic logic is_load(input memop_t op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    function automatic logic is_store(input memop_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: SRAM-like data bus between the memory stage and the data port.
//   master (core) : data_req, data_wr, data_size, data_addr, data_wdata
//   slave  (port) : data_addr_ok, data_data_ok, data_rdata
// Handshake: a request is accepted in the cycle where data_req and
// data_addr_ok are both high; address, size, write flag and write data are
// held stable by the master until then. Exactly one data_data_ok follows
// each accepted request, no earlier than the cycle after acceptance, and
// data_rdata is valid only in that data_data_ok cycle.
interface mem_stage_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_align.sv
// mem_align: combinational byte-lane logic for the memory stage.
//   memop, addr_lo : operation and low address bits
//   rdata          : raw bus read word
//   wdata          : register value to store
//   load_val       : selected and sign/zero-extended load result (little-endian)
//   store_data     : store value replicated across all byte lanes it may occupy
//   size           : bus size code for the operation
module mem_align
    import mem_defs::*;
(
    input  memop_t      memop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_data,
    output logic [1:0]  size
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_val   = rdata;
        store_data = wdata;
        size       = SIZE_WORD;
        case (memop)
            MEM_LB:  begin load_val = {{24{byte_sel[7]}}, byte_sel};  size = SIZE_BYTE; end
            MEM_LBU: begin load_val = {24'd0, byte_sel};              size = SIZE_BYTE; end
            MEM_LH:  begin load_val = {{16{half_sel[15]}}, half_sel}; size = SIZE_HALF; end
            MEM_LHU: begin load_val = {16'd0, half_sel};              size = SIZE_HALF; end
            MEM_SB:  begin store_data = {4{wdata[7:0]}};              size = SIZE_BYTE; end
            MEM_SH:  begin store_data = {2{wdata[15:0]}};             size = SIZE_HALF; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage of the MIPS core.
//   clk, resetn      : clock, synchronous active-low reset
//   stall, flush     : hazard-unit freeze / bubble insertion
//   *_e              : instruction fields from EX
//   *_m              : instruction fields and result to WB
//   adel_m, ades_m   : load / store address error, badvaddr_m = faulting address
//   stall_req        : request to freeze the pipeline while an access is pending
//   fsm_state        : current bus-access FSM state (observation only)
//   bus              : data bus master port
module mem_stage
    import mem_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_e,
    input  logic [31:0] aluout_e,
    input  logic [31:0] writedata_e,
    input  logic [4:0]  writereg_e,
    input  logic        regwrite_e,
    input  logic [3:0]  memop_e,
    input  logic        hilo_write_e,
    input  logic [63:0] hilo_e,
    output logic [31:0] pc_m,
    output logic [31:0] result_m,
    output logic [4:0]  writereg_m,
    output logic        regwrite_m,
    output logic        hilo_write_m,
    output logic [63:0] hilo_m,
    output logic        adel_m,
    output logic        ades_m,
    output logic [31:0] badvaddr_m,
    output logic        stall_req,
    output mem_state_t  fsm_state,
    mem_stage_if.master bus
);

    mem_state_t  state;
    m_reg_t      m;
    m_reg_t      m_next;
    mem_state_t  load_state;
    logic [31:0] rdata_q;
    logic [31:0] load_val;
    logic [31:0] store_data;
    logic [1:0]  size;
    memop_t      op_e;

    assign op_e = memop_t'(memop_e);

    // Value the M-register takes when it loads; address errors are decided
    // here so the registered flags are ready in the instruction's first M cycle.
    always_comb begin
        m_next = '0;
        if (!flush) begin
            m_next.pc         = pc_e;
            m_next.aluout     = aluout_e;
            m_next.writedata  = writedata_e;
            m_next.writereg   = writereg_e;
            m_next.regwrite   = regwrite_e;
            m_next.memop      = op_e;
            m_next.hilo_write = hilo_write_e;
            m_next.hilo       = hilo_e;
            m_next.adel = (((op_e == MEM_LH) || (op_e == MEM_LHU)) && aluout_e[0]) ||
                          ((op_e == MEM_LW) && (aluout_e[1:0] != 2'd0));
            m_next.ades = ((op_e == MEM_SH) && aluout_e[0]) ||
                          ((op_e == MEM_SW) && (aluout_e[1:0] != 2'd0));
            m_next.badvaddr = (m_next.adel || m_next.ades) ? aluout_e : 32'd0;
        end
        // A bubble carries memop NONE, so it always lands in IDLE.
        load_state = ((is_load(m_next.memop) || is_store(m_next.memop)) &&
                      !m_next.adel && !m_next.ades) ? ST_REQ : ST_IDLE;
    end

    // Bus FSM and M-register. A flush during REQ/WAIT kills the instruction
    // in M even while frozen, so a discarded load can never reach WB.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            m       <= '0;
            m.pc    <= RESET_PC;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (!stall) begin
                        m     <= m_next;
                        state <= load_state;
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        m     <= '0;
                        state <= ST_IDLE;
                    end else if (bus.data_addr_ok) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        m     <= '0;
                        state <= bus.data_data_ok ? ST_IDLE : ST_DRAIN;
                    end else if (bus.data_data_ok) begin
                        if (is_load(m.memop)) begin
                            rdata_q <= bus.data_rdata;
                        end
                        if (stall) begin
                            state <= ST_DONE;
                        end else begin
                            m     <= m_next;
                            state <= load_state;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.data_data_ok) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mem_align u_align (
        .memop      (m.memop),
        .addr_lo    (m.aluout[1:0]),
        .rdata      ((state == ST_DONE) ? rdata_q : bus.data_rdata),
        .wdata      (m.writedata),
        .load_val   (load_val),
        .store_data (store_data),
        .size       (size)
    );

    // data_req drops in the same cycle as a flush so no address is accepted.
    assign bus.data_req   = (state == ST_REQ) && !flush;
    assign bus.data_wr    = bus.data_req && is_store(m.memop);
    assign bus.data_size  = bus.data_req ? size : 2'd0;
    assign bus.data_addr  = bus.data_req ? m.aluout : 32'd0;
    assign bus.data_wdata = bus.data_req ? store_data : 32'd0;

    assign stall_req = (state == ST_REQ) || (state == ST_DRAIN) ||
                       ((state == ST_WAIT) && !bus.data_data_ok);

    assign pc_m         = m.pc;
    assign result_m     = (is_load(m.memop) && ((state == ST_WAIT) || (state == ST_DONE)))
                          ? load_val : m.aluout;
    assign writereg_m   = m.writereg;
    assign regwrite_m   = m.regwrite && !m.adel && !m.ades;
    assign hilo_write_m = m.hilo_write;
    assign hilo_m       = m.hilo;
    assign adel_m       = m.adel;
    assign ades_m       = m.ades;
    assign badvaddr_m   = m.badvaddr;
    assign fsm_state    = state;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage. The bench acts as
// hazard unit (stall = stall_req | ext_stall) and as the data-bus slave.
module tb_mem_stage;
    import mem_defs::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ext_stall;
    logic        stall;
    logic        flush;
    logic [31:0] pc_e, aluout_e, writedata_e;
    logic [4:0]  writereg_e;
    logic        regwrite_e;
    logic [3:0]  memop_e;
    logic        hilo_write_e;
    logic [63:0] hilo_e;
    logic [31:0] pc_m, result_m;
    logic [4:0]  writereg_m;
    logic        regwrite_m, hilo_write_m;
    logic [63:0] hilo_m;
    logic        adel_m, ades_m;
    logic [31:0] badvaddr_m;
    logic        stall_req;
    mem_state_t  fsm_state;

    mem_stage_if bus ();

    assign stall = stall_req | ext_stall;

    mem_stage #(.RESET_PC(32'hbfc00000)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .stall        (stall),
        .flush        (flush),
        .pc_e         (pc_e),
        .aluout_e     (aluout_e),
        .writedata_e  (writedata_e),
        .writereg_e   (writereg_e),
        .regwrite_e   (regwrite_e),
        .memop_e      (memop_e),
        .hilo_write_e (hilo_write_e),
        .hilo_e       (hilo_e),
        .pc_m         (pc_m),
        .result_m     (result_m),
        .writereg_m   (writereg_m),
        .regwrite_m   (regwrite_m),
        .hilo_write_m (hilo_write_m),
        .hilo_m       (hilo_m),
        .adel_m       (adel_m),
        .ades_m       (ades_m),
        .badvaddr_m   (badvaddr_m),
        .stall_req    (stall_req),
        .fsm_state    (fsm_state),
        .bus          (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_mis = 0;
    int stall_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        if (stall_req) stall_cnt++;
    endtask

    task automatic drive_ex(input logic [31:0] pc, input memop_t op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic rw);
        pc_e         = pc;
        memop_e      = op;
        aluout_e     = addr;
        writedata_e  = wdata;
        writereg_e   = 5'd7;
        regwrite_e   = rw;
        hilo_write_e = 1'b0;
        hilo_e       = 64'd0;
    endtask

    task automatic drive_nop();
        drive_ex(32'd0, MEM_NONE, 32'd0, 32'd0, 1'b0);
        writereg_e = 5'd0;
    endtask

    // Load with immediate addr_ok and next-cycle data_ok.
    task automatic run_load(input string tag, input memop_t op, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [1:0] exp_size,
                            input logic [31:0] exp_result);
        stall_cnt = 0;
        drive_ex(32'h100, op, addr, 32'd0, 1'b1);
        exp_q.push_back(exp_result);
        sample();
        next_cycle();
        drive_nop();
        bus.data_addr_ok = 1'b1;
        sample();
        check({tag, "_req"}, 64'(bus.data_req), 64'd1);
        check({tag, "_addr"}, 64'(bus.data_addr), 64'(addr));
        check({tag, "_size"}, 64'(bus.data_size), 64'(exp_size));
        check({tag, "_pc"}, 64'(pc_m), 64'h100);
        next_cycle();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = rdata;
        sample();
        check({tag, "_result"}, 64'(result_m), 64'(exp_q.pop_front()));
        check({tag, "_regwrite"}, 64'(regwrite_m), 64'd1);
        check({tag, "_writereg"}, 64'(writereg_m), 64'd7);
        next_cycle();
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'd0;
        sample();
        check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'd1);
        check({tag, "_idle"}, 64'(fsm_state), 64'(ST_IDLE));
        next_cycle();
    endtask

    task automatic run_store(input string tag, input memop_t op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_wdata,
                             input logic [1:0] exp_size);
        stall_cnt = 0;
        drive_ex(32'h180, op, addr, wdata, 1'b0);
        exp_q.push_back(addr);
        next_cycle();
        drive_nop();
        bus.data_addr_ok = 1'b1;
        sample();
        check({tag, "_wr"}, 64'(bus.data_wr), 64'd1);
        check({tag, "_wdata"}, 64'(bus.data_wdata), 64'(exp_wdata));
        check({tag, "_size"}, 64'(bus.data_size), 64'(exp_size));
        next_cycle();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        sample();
        check({tag, "_result"}, 64'(result_m), 64'(exp_q.pop_front()));
        next_cycle();
        bus.data_data_ok = 1'b0;
        sample();
        check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'd1);
        next_cycle();
    endtask

    task automatic run_addr_err(input string tag, input memop_t op, input logic [31:0] addr,
                                input logic exp_adel, input logic exp_ades);
        stall_cnt = 0;
        drive_ex(32'h1c0, op, addr, 32'h11111111, 1'b1);
        next_cycle();
        drive_nop();
        sample();
        check({tag, "_adel"}, 64'(adel_m), 64'(exp_adel));
        check({tag, "_ades"}, 64'(ades_m), 64'(exp_ades));
        check({tag, "_badvaddr"}, 64'(badvaddr_m), 64'(addr));
        check({tag, "_req"}, 64'(bus.data_req), 64'd0);
        check({tag, "_regwrite"}, 64'(regwrite_m), 64'd0);
        check({tag, "_stall"}, 64'(stall_cnt), 64'd0);
        next_cycle();
        sample();
        check({tag, "_cleared"}, 64'({adel_m, ades_m}), 64'd0);
        next_cycle();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        resetn           = 1'b0;
        ext_stall        = 1'b0;
        flush            = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'd0;
        drive_nop();

        // Reset state
        repeat (3) @(posedge clk);
        sample();
        check("rst_pc", 64'(pc_m), 64'hbfc00000);
        check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
        check("rst_result", 64'(result_m), 64'd0);
        check("rst_regwrite", 64'({regwrite_m, hilo_write_m, writereg_m}), 64'd0);
        check("rst_hilo", hilo_m, 64'd0);
        check("rst_err", 64'({adel_m, ades_m, badvaddr_m}), 64'd0);
        check("rst_bus", 64'({bus.data_req, bus.data_wr, bus.data_size, stall_req}), 64'd0);
        check("rst_addr", {bus.data_addr, bus.data_wdata}, 64'd0);
        next_cycle();
        resetn = 1'b1;
        next_cycle();

        // Loads with immediate handshakes
        run_load("lb3",  MEM_LB,  32'h1003, 32'h80FF1234, SIZE_BYTE, 32'hFFFFFF80);
        run_load("lhu2", MEM_LHU, 32'h1002, 32'h80FF1234, SIZE_HALF, 32'h000080FF);
        run_load("lh0",  MEM_LH,  32'h1000, 32'h80FF9234, SIZE_HALF, 32'hFFFF9234);
        run_load("lbu3", MEM_LBU, 32'h1003, 32'h80FF1234, SIZE_BYTE, 32'h00000080);
        run_load("lb1",  MEM_LB,  32'h1001, 32'h80FF1234, SIZE_BYTE, 32'h00000012);
        run_load("lw",   MEM_LW,  32'h1004, 32'h80FF1234, SIZE_WORD, 32'h80FF1234);

        // Stores
        run_store("sh6", MEM_SH, 32'h1006, 32'h1234ABCD, 32'hABCDABCD, SIZE_HALF);
        run_store("sb1", MEM_SB, 32'h1001, 32'h12345678, 32'h78787878, SIZE_BYTE);
        run_store("sw",  MEM_SW, 32'h1008, 32'hCAFEBABE, 32'hCAFEBABE, SIZE_WORD);

        // Address errors
        run_addr_err("lw1",  MEM_LW,  32'h1001, 1'b1, 1'b0);
        run_addr_err("lhu1", MEM_LHU, 32'h1003, 1'b1, 1'b0);
        run_addr_err("sw2",  MEM_SW,  32'h1002, 1'b0, 1'b1);

        // Non-memory instruction: one cycle, no stall
        stall_cnt = 0;
        drive_ex(32'h200, MEM_NONE, 32'hDEADBEEF, 32'd0, 1'b1);
        hilo_write_e = 1'b1;
        hilo_e       = 64'h1122334455667788;
        next_cycle();
        drive_nop();
        sample();
        check("alu_result", 64'(result_m), 64'hDEADBEEF);
        check("alu_hilo", hilo_m, 64'h1122334455667788);
        check("alu_hilo_write", 64'(hilo_write_m), 64'd1);
        check("alu_pc", 64'(pc_m), 64'h200);
        check("alu_stall", 64'({stall_req, bus.data_req}), 64'd0);
        next_cycle();

        // Flush while in REQ: request withdrawn
        drive_ex(32'h240, MEM_LW, 32'h4000, 32'd0, 1'b1);
        next_cycle();
        drive_nop();
        flush            = 1'b1;
        bus.data_addr_ok = 1'b1;
        sample();
        check("flreq_req", 64'(bus.data_req), 64'd0);
        next_cycle();
        flush            = 1'b0;
        bus.data_addr_ok = 1'b0;
        sample();
        check("flreq_state", 64'(fsm_state), 64'(ST_IDLE));
        check("flreq_regwrite", 64'({regwrite_m, stall_req}), 64'd0);
        next_cycle();

        // Flush after addr_ok, data_ok three cycles later: drain and discard
        drive_ex(32'h280, MEM_LW, 32'h2000, 32'd0, 1'b1);
        next_cycle();
        drive_nop();
        bus.data_addr_ok = 1'b1;
        next_cycle();
        bus.data_addr_ok = 1'b0;
        flush            = 1'b1;
        sample();
        check("drain_wait", 64'(fsm_state), 64'(ST_WAIT));
        next_cycle();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            check("drain_state", 64'(fsm_state), 64'(ST_DRAIN));
            check("drain_stall", 64'(stall_req), 64'd1);
            next_cycle();
        end
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hCAFEF00D;
        sample();
        check("drain_last_stall", 64'(stall_req), 64'd1);
        next_cycle();
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'd0;
        sample();
        check("drain_idle", 64'(fsm_state), 64'(ST_IDLE));
        check("drain_discard", 64'({result_m, regwrite_m, stall_req}), 64'd0);
        next_cycle();

        // SW with addr_ok delayed four cycles, stall held after data_ok
        drive_ex(32'h300, MEM_SW, 32'h3008, 32'h55AA55AA, 1'b0);
        exp_q.push_back(32'h3008);
        next_cycle();
        drive_nop();
        for (int i = 0; i < 4; i++) begin
            sample();
            check("swd_req", 64'({bus.data_req, bus.data_wr}), 64'h3);
            check("swd_addr", {bus.data_addr, bus.data_wdata}, {32'h3008, 32'h55AA55AA});
            next_cycle();
        end
        bus.data_addr_ok = 1'b1;
        sample();
        check("swd_accept", 64'(bus.data_req), 64'd1);
        next_cycle();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        ext_stall        = 1'b1;
        sample();
        check("swd_dok_stall_req", 64'(stall_req), 64'd0);
        check("swd_result", 64'(result_m), 64'(exp_q.pop_front()));
        next_cycle();
        bus.data_data_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            check("swd_done", 64'(fsm_state), 64'(ST_DONE));
            check("swd_done_bus", 64'({bus.data_req, stall_req}), 64'd0);
            check("swd_done_out", {pc_m, result_m}, {32'h300, 32'h3008});
            next_cycle();
        end
        ext_stall = 1'b0;
        drive_ex(32'h400, MEM_NONE, 32'h44, 32'd0, 1'b0);
        next_cycle();
        drive_nop();
        sample();
        check("swd_release", 64'({pc_m, 1'b0, fsm_state}), 64'({32'h400, 1'b0, ST_IDLE}));
        next_cycle();

        // LH finishing in DONE: result comes from the captured read data
        drive_ex(32'h500, MEM_LH, 32'h1002, 32'd0, 1'b1);
        exp_q.push_back(32'hFFFFF00D);
        next_cycle();
        drive_nop();
        bus.data_addr_ok = 1'b1;
        next_cycle();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hF00D1234;
        ext_stall        = 1'b1;
        next_cycle();
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = $urandom_range(32'hFFFF, 0);
        sample();
        check("lhdone_state", 64'(fsm_state), 64'(ST_DONE));
        check("lhdone_result", 64'(result_m), 64'(exp_q.pop_front()));
        ext_stall = 1'b0;
        next_cycle();
        bus.data_rdata = 32'd0;
        sample();
        check("lhdone_release", 64'(fsm_state), 64'(ST_IDLE));

        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory pipeline stage of the MIPS core. It sits between the execute stage and the writeback stage. Each cycle it holds one instruction in its M-register. For loads and stores it runs one transaction on the SRAM-like data bus, handling address-error detection, store lane generation and load extraction with sign/zero extension. It stalls the pipeline until the access completes, then presents result, destination register and HI/LO to writeback.

## Interface
Parameters:
- RESET_PC, 32'hbfc00000, PC value held in the M-register after reset.

Ports (reset is synchronous, active-low `resetn`; clock is `clk`):
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- stall  in  1  hazard unit freeze; M-register holds when 1
- flush  in  1  load a bubble into the M-register (applies only when stall=0)
- pc_e, aluout_e, writedata_e  in  32 each  from EX
- writereg_e  in  5  destination register
- regwrite_e  in  1  register write enable
- memop_e  in  4  memory op code: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW
- hilo_write_e  in  1  HI/LO write enable
- hilo_e  in  64  HI/LO value
- pc_m, result_m  out  32  to WB
- writereg_m  out  5  to WB
- regwrite_m, hilo_write_m  out  1  to WB
- hilo_m  out  64  to WB
- adel_m, ades_m  out  1  load/store address error
- badvaddr_m  out  32  faulting address
- stall_req  out  1  to hazard unit
- data_req, data_wr  out  1  bus request, write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr, data_wdata  out  32
- data_addr_ok, data_data_ok  in  1  bus handshakes
- data_rdata  in  32  read data

## Operation
- M-register load:
  - On ~stall, capture all EX inputs.
  - If flush, load a bubble instead: memop NONE, regwrite 0, hilo_write 0, pc 0.
- Address errors are computed from the EX inputs when the M-register loads, then registered:
  - LH/LHU/SH with addr[0]≠0.
  - LW/SW with addr[1:0]≠0.
- An excepting instruction issues no bus access, and regwrite_m is forced to 0.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN. Next state on M-register load:
  - REQ if the incoming op is a memory op with no error and no flush.
  - IDLE otherwise.
- REQ:
  - data_req=1; address, size and wdata are driven from the M-register.
  - On data_addr_ok go to WAIT.
- WAIT: data_req=0.
  - On data_data_ok with a load, capture data_rdata into rdata_q.
  - If stall=1 at that point, go to DONE.
  - Otherwise follow the M-register load rule.
- DONE: hold, with no bus activity, until ~stall.
- stall_req is asserted in REQ, in DRAIN, and in WAIT while ~data_data_ok.
- Flush while an access is outstanding:
  - In REQ: drop data_req and go to IDLE; no address has been accepted yet.
  - In WAIT: go to DRAIN with stall_req=1, wait for data_data_ok, discard the data, go to IDLE.
- Store lanes: data_wdata is SB byte ×4, SH half ×2, SW word; data_addr is the full byte address.
- Load result, little-endian:
  - Byte select = addr[1:0]; half select = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Source is data_rdata in WAIT, rdata_q in DONE.
- Non-load result: result_m = aluout.
- hilo, pc, writereg pass through unchanged.

## Timing
- Reset state:
  - FSM IDLE.
  - pc_m = RESET_PC.
  - All other outputs 0: result, writereg, regwrite, hilo, hilo_write, adel, ades, badvaddr, data_req, data_wr, data_size, data_addr, data_wdata, stall_req.
  - Reset overrides an outstanding transaction; the bus is reset with the core.
- Access sequence:
  - The request is issued in the first cycle the op is in M.
  - data_data_ok is honoured no earlier than the cycle after data_addr_ok.
- Minimum stall:
  - Load with immediate addr_ok and next-cycle data_ok: 1 cycle of stall_req, 2 cycles in M.
  - Stores behave identically.
- Non-memory instructions: 1 cycle in M, no stall_req.
- Held while stall=1: outputs hold, and the bus is held in REQ.

## Structure
- Package mem_defs holds:
  - memop encodings;
  - FSM state encoding;
  - data_size constants.
- Sub-module mem_align, combinational:
  - inputs memop, addr[1:0], rdata, wdata;
  - outputs extended load value, lane-replicated store data, data_size.
- The FSM and M-register stay in mem_stage.

## Test plan
- LB at addr 0x...03 with rdata 0x80FF_1234, addr_ok and data_ok immediate → result_m=0xFFFFFF80, stall_req high exactly 1 cycle.
- LHU at addr 0x...02, same rdata → result_m=0x00008 0FF (0x000080FF).
- SH at 0x...06 with writedata 0x1234ABCD → data_wdata=0xABCDABCD, data_size=1, data_wr=1.
- LW at 0x...01 → adel_m=1, badvaddr_m=addr, no data_req, regwrite_m=0.
- Flush after addr_ok with data_ok delayed 3 cycles → state DRAIN, stall_req high until data_ok, then IDLE with data discarded.
- SW with addr_ok delayed 4 cycles and stall held high after data_ok → data_req held steady, then DONE, with outputs stable until stall drops.
